// File: rtl/fpu_fas_arbiter.sv
// fpu_fas_arbiter
//
// Shares one pipelined FP add/sub unit between two requesters. Each cycle at
// most one request is granted, round-robin on ties. The granted operands are
// registered onto the unit bus together with a single-cycle add or sub strobe.
// The issuing port's ID is pushed into an in-order ID FIFO. Each result pulse
// from the unit pops the head ID. The result is then returned, registered, to
// the port that issued the operation.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   req0/op0/a0/b0 -> gnt0   port 0 request (op: 0=add, 1=sub), combinational grant
//   req1/op1/a1/b1 -> gnt1   port 1 request, combinational grant
//   fpu_do_fadd/fpu_do_fsub  one-cycle strobes to the unit
//   fpu_a/fpu_b              registered operands to the unit
//   fpu_q/fpu_valid          in-order result and result pulse from the unit
//   rsp_q                    registered result
//   rsp0_valid/rsp1_valid    one-cycle pulse naming the owner of rsp_q
//   busy                     operations in flight or a strobe on the bus
//   err_orphan               sticky: result pulse seen with nothing in flight
module fpu_fas_arbiter #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        gnt0,
  input  logic        req1,
  input  logic        op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt1,
  output logic        fpu_do_fadd,
  output logic        fpu_do_fsub,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_q,
  input  logic        fpu_valid,
  output logic [31:0] rsp_q,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic        busy,
  output logic        err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] id_mem;
  // Port that wins the next tie; it flips away from whichever port was granted.
  logic             rr_ptr;

  logic             accept;
  logic             grant;
  logic             win_id;
  logic             win_op;
  logic [31:0]      win_a;
  logic [31:0]      win_b;
  logic             pop;
  logic             head_id;

  // Arbitration and handshake. Accept uses the count before any pop in this
  // cycle, so a full FIFO cannot grant even when a result is retiring.
  always_comb begin
    accept  = (count < DEPTH_C);
    win_id  = 1'b0;
    if (req0 && req1) begin
      win_id = rr_ptr;
    end else if (req1) begin
      win_id = 1'b1;
    end
    grant   = accept && (req0 || req1);
    gnt0    = grant && !win_id;
    gnt1    = grant && win_id;
    win_op  = win_id ? op1 : op0;
    win_a   = win_id ? a1 : a0;
    win_b   = win_id ? b1 : b0;
    pop     = fpu_valid && (count != '0);
    head_id = id_mem[rd_ptr];
  end

  // The strobe term matters only in the issue cycle; count has already
  // been incremented by then, but the bus activity is named explicitly.
  assign busy = (count != '0) || fpu_do_fadd || fpu_do_fsub;

  // Issue path: operands are captured only on a grant and held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_do_fadd <= 1'b0;
      fpu_do_fsub <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      rr_ptr      <= 1'b0;
    end else begin
      fpu_do_fadd <= grant && !win_op;
      fpu_do_fsub <= grant && win_op;
      if (grant) begin
        fpu_a  <= win_a;
        fpu_b  <= win_b;
        rr_ptr <= !win_id;
      end
    end
  end

  // The ID storage needs no reset: an entry is only read between its push
  // and its pop, and reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (grant) begin
      id_mem[wr_ptr] <= win_id;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the count
  // unchanged. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Completion: the result is registered and tagged with the head ID. A
  // result pulse with nothing in flight only raises the sticky orphan flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      rsp0_valid <= pop && !head_id;
      rsp1_valid <= pop && head_id;
      if (pop) begin
        rsp_q <= fpu_q;
      end
      if (fpu_valid && (count == '0)) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fas_arbiter.sv
// tb_fpu_fas_arbiter
//
// Self-checking bench for fpu_fas_arbiter. Each cycle the bench drives the
// pending requests of two requester models and an optional result pulse. It
// then compares the grants and registered outputs against a reference. The
// reference is a queue of in-flight port IDs plus a tie-break preference.
module tb_fpu_fas_arbiter;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        req0, op0, req1, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        fpu_do_fadd, fpu_do_fsub;
  logic [31:0] fpu_a, fpu_b, fpu_q;
  logic        fpu_valid;
  logic [31:0] rsp_q;
  logic        rsp0_valid, rsp1_valid, busy, err_orphan;

  int check_count;
  int pass_count;

  // Requester state: a request stays pending until the model grants it.
  logic        pend0, pend_op0, pend1, pend_op1;
  logic [31:0] pend_a0, pend_b0, pend_a1, pend_b1;

  // Reference model state.
  int          inflight[$];
  int          rr_pref;
  logic [31:0] exp_a, exp_b, exp_rsp_q;
  logic        exp_orphan;

  fpu_fas_arbiter #(.DEPTH(DEPTH), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .fpu_do_fadd(fpu_do_fadd), .fpu_do_fsub(fpu_do_fsub),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_q(fpu_q), .fpu_valid(fpu_valid),
    .rsp_q(rsp_q), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .busy(busy), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Creates a new pending request; opsel < 0 picks a random op.
  task automatic makeReq(input int port, input int opsel);
    logic o;
    o = (opsel < 0) ? 1'($urandom_range(0, 1)) : 1'(opsel);
    if (port == 0) begin
      pend0 = 1'b1; pend_op0 = o; pend_a0 = $urandom; pend_b0 = $urandom;
    end else begin
      pend1 = 1'b1; pend_op1 = o; pend_a1 = $urandom; pend_b1 = $urandom;
    end
  endtask

  // Drives one cycle starting just after a rising edge and checks the grants
  // mid-cycle. It then checks the registered outputs just after the next edge.
  task automatic applyStimulus(input logic fv_in, input logic [31:0] fq_in);
    logic acc, granted, win_op, exp_fadd, exp_fsub, exp_r0, exp_r1;
    int   win;
    int   head;
    req0 = pend0; op0 = pend_op0; a0 = pend_a0; b0 = pend_b0;
    req1 = pend1; op1 = pend_op1; a1 = pend_a1; b1 = pend_b1;
    fpu_valid = fv_in; fpu_q = fq_in;
    #2;
    acc     = (inflight.size() < DEPTH);
    granted = acc && (pend0 || pend1);
    if (pend0 && pend1) win = rr_pref;
    else if (pend0)     win = 0;
    else                win = 1;
    checkOutput("gnt0", {31'd0, gnt0}, {31'd0, granted && (win == 0)});
    checkOutput("gnt1", {31'd0, gnt1}, {31'd0, granted && (win == 1)});
    exp_fadd = 1'b0; exp_fsub = 1'b0; exp_r0 = 1'b0; exp_r1 = 1'b0;
    if (granted) begin
      win_op   = (win == 0) ? pend_op0 : pend_op1;
      exp_a    = (win == 0) ? pend_a0 : pend_a1;
      exp_b    = (win == 0) ? pend_b0 : pend_b1;
      exp_fadd = !win_op;
      exp_fsub = win_op;
    end
    if (fv_in) begin
      if (inflight.size() != 0) begin
        head      = inflight.pop_front();
        exp_rsp_q = fq_in;
        if (head == 0) exp_r0 = 1'b1;
        else           exp_r1 = 1'b1;
      end else begin
        exp_orphan = 1'b1;
      end
    end
    if (granted) begin
      inflight.push_back(win);
      rr_pref = 1 - win;
      if (win == 0) pend0 = 1'b0;
      else          pend1 = 1'b0;
    end
    @(posedge clk);
    #1;
    fpu_valid = 1'b0;
    checkOutput("fadd", {31'd0, fpu_do_fadd}, {31'd0, exp_fadd});
    checkOutput("fsub", {31'd0, fpu_do_fsub}, {31'd0, exp_fsub});
    checkOutput("fpu_a", fpu_a, exp_a);
    checkOutput("fpu_b", fpu_b, exp_b);
    checkOutput("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, exp_r0});
    checkOutput("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, exp_r1});
    checkOutput("rsp_q", rsp_q, exp_rsp_q);
    checkOutput("err_orphan", {31'd0, err_orphan}, {31'd0, exp_orphan});
    checkOutput("busy", {31'd0, busy},
                {31'd0, (inflight.size() != 0) || exp_fadd || exp_fsub});
  endtask

  // Asserts reset away from the clock edge, checks that every output clears
  // immediately, and releases reset one cycle later.
  task automatic doReset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; fpu_valid = 1'b0; fpu_q = '0;
    #1;
    checkOutput("rst_fadd", {31'd0, fpu_do_fadd}, 32'd0);
    checkOutput("rst_fsub", {31'd0, fpu_do_fsub}, 32'd0);
    checkOutput("rst_fpu_a", fpu_a, 32'd0);
    checkOutput("rst_fpu_b", fpu_b, 32'd0);
    checkOutput("rst_rsp_q", rsp_q, 32'd0);
    checkOutput("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_orphan", {31'd0, err_orphan}, 32'd0);
    checkOutput("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    inflight.delete();
    rr_pref = 0; exp_a = '0; exp_b = '0; exp_rsp_q = '0; exp_orphan = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    check_count = 0; pass_count = 0;
    rst = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0; pend_op0 = 1'b0; pend_op1 = 1'b0;
    pend_a0 = '0; pend_b0 = '0; pend_a1 = '0; pend_b1 = '0;
    @(posedge clk);
    #1;
    doReset();

    // Single add from port 0 and its result.
    $display("[TB] directed add on port 0");
    pend0 = 1'b1; pend_op0 = 1'b0; pend_a0 = 32'h3F800000; pend_b0 = 32'h40000000;
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b1, 32'h40400000);
    applyStimulus(1'b0, 32'd0);

    // Both ports held: grants alternate starting with port 0 after reset.
    $display("[TB] alternating grants");
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (!pend0) makeReq(0, -1);
      if (!pend1) makeReq(1, -1);
      applyStimulus(1'b0, 32'd0);
    end
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom);

    // Port 1 fills the FIFO; a result while full still blocks that cycle.
    $display("[TB] full FIFO behaviour");
    doReset();
    for (int i = 0; i < 10; i++) begin
      if (!pend1) makeReq(1, 1);
      applyStimulus(1'b0, 32'd0);
    end
    applyStimulus(1'b1, $urandom);
    applyStimulus(1'b0, 32'd0);
    pend1 = 1'b0;
    for (int i = 0; i < 20 && inflight.size() > 3; i++) applyStimulus(1'b1, $urandom);
    makeReq(0, 0);
    applyStimulus(1'b1, $urandom);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom);
    applyStimulus(1'b0, 32'd0);

    // Orphan result after reset is sticky until reset.
    $display("[TB] orphan result");
    doReset();
    applyStimulus(1'b1, $urandom);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0);

    // Reset with four in flight, then a normal add and a stray result.
    $display("[TB] reset with operations in flight");
    doReset();
    for (int i = 0; i < 4; i++) begin
      makeReq(i % 2, -1);
      applyStimulus(1'b0, 32'd0);
    end
    doReset();
    makeReq(0, 0);
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b1, $urandom);
    applyStimulus(1'b1, $urandom);

    // Randomized traffic.
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && ($urandom_range(0, 9) < 6)) makeReq(0, -1);
      if (!pend1 && ($urandom_range(0, 9) < 6)) makeReq(1, -1);
      if (inflight.size() != 0) applyStimulus(1'($urandom_range(0, 2) == 0), $urandom);
      else                      applyStimulus(1'($urandom_range(0, 29) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fpu_fas_arbiter.md
Name: fpu_fas_arbiter

Overview:
- Shares one pipelined FP add/sub unit between two requesters (port 0, port 1).
- Grants one operation per cycle, round-robin, and drives the unit's single-cycle do_fadd/do_fsub strobes and operands.
- Tracks in-flight operations in an ID FIFO and routes each in-order result back to the port that issued it.
- Sits between the two client blocks and the add/sub unit.

Parameters:
- DEPTH, 8, maximum in-flight operations and depth of the ID FIFO (power of two, >=2).
- CW, 4, width of the in-flight counter (must hold DEPTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held with op0/a0/b0 until gnt0.
- op0  input  1  port 0 op: 0=add, 1=sub.
- a0  input  32  port 0 operand A (IEEE-754 single).
- b0  input  32  port 0 operand B.
- gnt0  output  1  combinational; request accepted this cycle.
- req1, op1, a1, b1, gnt1  as port 0.
- fpu_do_fadd  output  1  one-cycle add strobe to the unit.
- fpu_do_fsub  output  1  one-cycle sub strobe to the unit.
- fpu_a  output  32  registered operand A to the unit.
- fpu_b  output  32  registered operand B to the unit.
- fpu_q  input  32  result from the unit.
- fpu_valid  input  1  one-cycle result pulse from the unit; results arrive in issue order.
- rsp_q  output  32  registered result.
- rsp0_valid  output  1  one-cycle pulse: rsp_q belongs to port 0.
- rsp1_valid  output  1  one-cycle pulse: rsp_q belongs to port 1.
- busy  output  1  high when in-flight count != 0 or a strobe is on the bus.
- err_orphan  output  1  sticky: fpu_valid arrived with nothing in flight.

Behaviour:
- Reset values (rst low, asynchronous):
  - fpu_do_fadd, fpu_do_fsub, rsp0_valid, rsp1_valid, busy, err_orphan = 0.
  - fpu_a, fpu_b, rsp_q = 0.
  - count = 0; FIFO pointers = 0; rr pointer selects port 0 first.
- Reset mid-operation discards all in-flight IDs. A later stray fpu_valid counts as an orphan.
- Accept condition: count < DEPTH (ID FIFO not full).
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port not served last wins.
  - The rr pointer updates only on a grant.
- Grant handshake:
  - gnt_i = accept && winner_i, combinational, in cycle T.
  - The requester may change or drop its inputs in T+1.
  - No grant while full; requests stay pending with no loss and no duplicate issue.
- Issue:
  - At the edge ending T, fpu_a/fpu_b register the winner's operands.
  - Exactly one of fpu_do_fadd/fpu_do_fsub pulses high for cycle T+1, per op.
  - The winner's ID (0/1) is pushed into the FIFO and count increments.
  - Back-to-back grants in consecutive cycles are allowed.
- Completion:
  - On fpu_valid with count != 0: pop the head ID and register rsp_q = fpu_q.
  - The matching rspN_valid pulses one cycle after fpu_valid.
- Simultaneous grant and fpu_valid: push and pop both occur and count is unchanged. A full FIFO still cannot grant that cycle, because the accept check uses the pre-pop count.
- Orphan case: fpu_valid with count == 0 sets err_orphan (cleared only by reset). No rsp pulse; count stays 0.
- FIFO pointers wrap modulo DEPTH; count saturates at neither end beyond these rules.

Test Plan:
- Port 0 add, a0=0x3F800000, b0=0x40000000 → gnt0 in T; fpu_do_fadd=1 and fpu_a=0x3F800000 in T+1; bench returns fpu_q=0x40400000 → rsp0_valid=1, rsp_q=0x40400000 next cycle.
- req0 and req1 held high for 6 grants → grants alternate 0,1,0,1,0,1 starting with port 0 after reset; responses return in the same order with correct rspN_valid.
- Port 1 issues 8 subs with no fpu_valid → gnt1 stops after the 8th and busy=1. One fpu_valid → grant resumes the same cycle count drops (next cycle). No op is dropped or duplicated.
- count=8 plus a simultaneous fpu_valid and a pending req → no grant that cycle, grant the next. Then at count=3, a simultaneous grant and fpu_valid → count remains 3.
- fpu_valid pulse after reset with nothing issued → err_orphan=1 persists, no rsp pulses. Reset low → all outputs 0.
- Assert rst low with 4 ops in flight → outputs clear immediately. A new add afterwards issues and responds normally.
